// File: rtl/setpoint_sequencer.sv
// Setpoint sequencer: picks one of eight presets through the external setpoint
// mux and slews the loop setpoint toward it in steps of at most STEP. Each step
// happens every TICK_DIV clocks while en is high. After reset it soft-starts
// from 0 toward preset 0.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   en        ramp enable; low freezes the ramp and the tick counter
//   btn_up    debounced level; rising edge selects the next preset
//   btn_down  debounced level; rising edge selects the previous preset
//   mux_y     preset value returned combinationally by the mux for sel
//   sel       preset select driving the mux (registered)
//   setpoint  ramped setpoint to the control loop (registered)
//   busy      high while a ramp is pending or running (registered)
//   done      one-cycle pulse when the setpoint lands on its target (registered)
module setpoint_sequencer #(
    parameter int unsigned W        = 12,
    parameter int unsigned STEP     = 16,
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic [W-1:0] mux_y,
    output logic [2:0]   sel,
    output logic [W-1:0] setpoint,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [W:0]    STEP_WIDE = (W + 1)'(STEP);
    localparam logic [W-1:0]  STEP_N    = W'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RAMP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic          r_up_q;
    logic          r_dn_q;
    logic [2:0]    r_sel;
    logic [W-1:0]  r_setpoint;
    logic [W-1:0]  r_target;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic          w_up_edge;
    logic          w_dn_edge;
    logic          w_up_ok;
    logic          w_dn_ok;
    logic          w_move;
    logic [2:0]    w_sel_moved;
    logic          w_tick;
    logic signed [W:0] w_diff;
    logic [W:0]    w_abs;
    logic          w_close;

    logic [2:0]    w_sel_nxt;
    logic [W-1:0]  w_setpoint_nxt;
    logic [W-1:0]  w_target_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // Request decode: rising edges only; simultaneous edges and moves past
    // either end of the preset table are dropped.
    always_comb begin
        w_up_edge   = btn_up & ~r_up_q;
        w_dn_edge   = btn_down & ~r_dn_q;
        w_up_ok     = w_up_edge & ~w_dn_edge & (r_sel != 3'd7);
        w_dn_ok     = w_dn_edge & ~w_up_edge & (r_sel != 3'd0);
        w_move      = w_up_ok | w_dn_ok;
        w_sel_moved = w_up_ok ? (r_sel + 3'd1) : (r_sel - 3'd1);
    end

    // Distance to target; one extra bit keeps the signed difference exact.
    always_comb begin
        w_tick  = en & (r_cnt == TICK_LAST);
        w_diff  = $signed({1'b0, r_target}) - $signed({1'b0, r_setpoint});
        w_abs   = w_diff[W] ? (W + 1)'(-w_diff) : (W + 1)'(w_diff);
        w_close = (w_abs <= STEP_WIDE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a valid request during a ramp restarts from LOAD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_move) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RAMP;
            end
            S_RAMP: begin
                if (w_move) begin
                    w_state_nxt = S_LOAD;
                end else if (w_tick && w_close) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        w_sel_nxt      = r_sel;
        w_setpoint_nxt = r_setpoint;
        w_target_nxt   = r_target;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_move) begin
                    w_sel_nxt = w_sel_moved;
                end
            end
            S_LOAD: begin
                w_target_nxt = mux_y;
                w_cnt_nxt    = '0;
            end
            S_RAMP: begin
                if (w_move) begin
                    // Setpoint is left alone so the new ramp starts where this one stopped.
                    w_sel_nxt = w_sel_moved;
                end else if (en) begin
                    if (r_cnt == TICK_LAST) begin
                        w_cnt_nxt = '0;
                        if (w_close) begin
                            w_setpoint_nxt = r_target;
                            w_done_nxt     = 1'b1;
                        end else if (!w_diff[W]) begin
                            w_setpoint_nxt = r_setpoint + STEP_N;
                        end else begin
                            w_setpoint_nxt = r_setpoint - STEP_N;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_q     <= 1'b0;
            r_dn_q     <= 1'b0;
            r_sel      <= 3'd0;
            r_setpoint <= '0;
            r_target   <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_up_q     <= btn_up;
            r_dn_q     <= btn_down;
            r_sel      <= w_sel_nxt;
            r_setpoint <= w_setpoint_nxt;
            r_target   <= w_target_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign sel      = r_sel;
    assign setpoint = r_setpoint;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_setpoint_sequencer.sv
// Directed bench for setpoint_sequencer with TICK_DIV=4, STEP=16 and a
// behavioural preset mux. Expected values are hand-computed per scenario.
module tb_setpoint_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        btn_up;
    logic        btn_down;
    logic [11:0] mux_y;
    logic [2:0]  sel;
    logic [11:0] setpoint;
    logic        busy;
    logic        done;

    logic [11:0] presets [0:7];
    int n_checks;
    int n_fail;

    setpoint_sequencer #(.W(12), .STEP(16), .TICK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .mux_y    (mux_y),
        .sel      (sel),
        .setpoint (setpoint),
        .busy     (busy),
        .done     (done)
    );

    assign mux_y = presets[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_up();
        btn_up = 1'b1;
        step(1);
        btn_up = 1'b0;
    endtask

    task automatic press_down();
        btn_down = 1'b1;
        step(1);
        btn_down = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (done !== 1'b1 && n < max) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
        n_checks++; if (setpoint !== 12'h000) begin n_fail++; $display("FAIL reset_setpoint: got %h want 000", setpoint); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_soft_start();
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ss_busy_pre: got %b want 0", busy); end
        step(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ss_busy_rise: got %b want 1", busy); end
        for (int k = 1; k <= 16; k++) begin
            step(3);
            n_checks++; if (setpoint !== 12'(16 * (k - 1))) begin n_fail++; $display("FAIL ss_hold k=%0d: got %h want %h", k, setpoint, 12'(16 * (k - 1))); end
            step(1);
            n_checks++; if (setpoint !== 12'(16 * k)) begin n_fail++; $display("FAIL ss_step k=%0d: got %h want %h", k, setpoint, 12'(16 * k)); end
            n_checks++; if (done !== (k == 16)) begin n_fail++; $display("FAIL ss_done k=%0d: got %b", k, done); end
            n_checks++; if (busy !== (k != 16)) begin n_fail++; $display("FAIL ss_busy k=%0d: got %b", k, busy); end
        end
        step(1);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ss_done_pulse: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ss_idle_busy: got %b want 0", busy); end
        n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL ss_sel: got %0d want 0", sel); end
    endtask

    task automatic test_bounds_low();
        press_down();
        n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL low_sel: got %0d want 0", sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL low_busy: got %b want 0", busy); end
        step(3);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL low_quiet: got busy=%b done=%b want 0/0", busy, done); end
        n_checks++; if (setpoint !== 12'h100) begin n_fail++; $display("FAIL low_setpoint: got %h want 100", setpoint); end
        btn_up   = 1'b1;
        btn_down = 1'b1;
        step(1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL conflict_sel: got %0d want 0", sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL conflict_busy: got %b want 0", busy); end
        step(3);
        n_checks++; if (sel !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL conflict_quiet: got sel=%0d busy=%b done=%b want 0/0/0", sel, busy, done); end
    endtask

    task automatic test_small_move();
        press_up();
        n_checks++; if (sel !== 3'd1) begin n_fail++; $display("FAIL small_sel: got %0d want 1", sel); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL small_busy: got %b want 1", busy); end
        step(4);
        n_checks++; if (setpoint !== 12'h100 || done !== 1'b0) begin n_fail++; $display("FAIL small_before: got %h done=%b want 100 done=0", setpoint, done); end
        step(1);
        n_checks++; if (setpoint !== 12'h0F8) begin n_fail++; $display("FAIL small_setpoint: got %h want 0f8", setpoint); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL small_done: got done=%b busy=%b want 1/0", done, busy); end
        step(1);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL small_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_multi_step_down();
        int n;
        press_up();
        step(5);
        n_checks++; if (setpoint !== 12'h0E8) begin n_fail++; $display("FAIL down_first: got %h want 0e8", setpoint); end
        wait_done(60, n);
        n_checks++; if (n !== 28) begin n_fail++; $display("FAIL down_latency: got %0d cycles want 28", n); end
        n_checks++; if (setpoint !== 12'h080 || sel !== 3'd2) begin n_fail++; $display("FAIL down_final: got %h sel=%0d want 080 sel=2", setpoint, sel); end
        step(1);
    endtask

    task automatic test_retarget();
        int k;
        int dones;
        logic [11:0] exp_sp;
        press_up();
        step(97);
        n_checks++; if (setpoint !== 12'h200 || sel !== 3'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL rt_mid: got %h sel=%0d busy=%b want 200 sel=3 busy=1", setpoint, sel, busy); end
        press_down();
        n_checks++; if (sel !== 3'd2 || setpoint !== 12'h200) begin n_fail++; $display("FAIL rt_sel: got sel=%0d sp=%h want 2 200", sel, setpoint); end
        dones = 0;
        for (int c = 1; c <= 100; c++) begin
            step(1);
            k = (c - 1) / 4;
            if (k > 24) k = 24;
            exp_sp = 12'(12'h200 - 16 * k);
            if (done === 1'b1) dones++;
            n_checks++; if (setpoint !== exp_sp) begin n_fail++; $display("FAIL rt_sp c=%0d: got %h want %h", c, setpoint, exp_sp); end
            n_checks++; if (done !== (c == 97)) begin n_fail++; $display("FAIL rt_done c=%0d: got %b", c, done); end
        end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL rt_done_count: got %0d want 1", dones); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rt_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_freeze();
        press_up();
        step(5);
        n_checks++; if (setpoint !== 12'h090) begin n_fail++; $display("FAIL frz_start: got %h want 090", setpoint); end
        step(1);
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            n_checks++; if (setpoint !== 12'h090 || busy !== 1'b1) begin n_fail++; $display("FAIL frz_hold c=%0d: got %h busy=%b want 090 1", c, setpoint, busy); end
        end
        en = 1'b1;
        step(2);
        n_checks++; if (setpoint !== 12'h090) begin n_fail++; $display("FAIL frz_resume_early: got %h want 090", setpoint); end
        step(1);
        n_checks++; if (setpoint !== 12'h0A0) begin n_fail++; $display("FAIL frz_resume_step: got %h want 0a0", setpoint); end
    endtask

    task automatic test_reset_mid_ramp();
        int n;
        step(152);
        n_checks++; if (setpoint !== 12'h300 || sel !== 3'd3) begin n_fail++; $display("FAIL rst_pre: got %h sel=%0d want 300 sel=3", setpoint, sel); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (setpoint !== 12'h000 || sel !== 3'd0) begin n_fail++; $display("FAIL rst_async: got %h sel=%0d want 000 sel=0", setpoint, sel); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_async_flags: got busy=%b done=%b want 0/0", busy, done); end
        step(2);
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_pre: got %b want 0", busy); end
        step(1);
        n_checks++; if (busy !== 1'b1 || setpoint !== 12'h000) begin n_fail++; $display("FAIL rst_restart: got busy=%b sp=%h want 1 000", busy, setpoint); end
        step(4);
        n_checks++; if (setpoint !== 12'h010) begin n_fail++; $display("FAIL rst_first_step: got %h want 010", setpoint); end
        wait_done(100, n);
        n_checks++; if (n !== 60) begin n_fail++; $display("FAIL rst_latency: got %0d cycles want 60", n); end
        n_checks++; if (setpoint !== 12'h100 || sel !== 3'd0) begin n_fail++; $display("FAIL rst_final: got %h sel=%0d want 100 sel=0", setpoint, sel); end
        step(1);
    endtask

    task automatic test_bounds_high();
        int n;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step(2);
            press_up();
        end
        n_checks++; if (sel !== 3'd7 || setpoint !== 12'h100 || busy !== 1'b1) begin n_fail++; $display("FAIL high_climb: got sel=%0d sp=%h busy=%b want 7 100 1", sel, setpoint, busy); end
        wait_done(40, n);
        n_checks++; if (n !== 17) begin n_fail++; $display("FAIL high_latency: got %0d cycles want 17", n); end
        n_checks++; if (setpoint !== 12'h0C0) begin n_fail++; $display("FAIL high_setpoint: got %h want 0c0", setpoint); end
        step(1);
        press_up();
        n_checks++; if (sel !== 3'd7 || busy !== 1'b0) begin n_fail++; $display("FAIL high_ignore: got sel=%0d busy=%b want 7 0", sel, busy); end
        step(3);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || setpoint !== 12'h0C0) begin n_fail++; $display("FAIL high_quiet: got busy=%b done=%b sp=%h want 0 0 0c0", busy, done, setpoint); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        presets[0] = 12'h100;
        presets[1] = 12'h0F8;
        presets[2] = 12'h080;
        presets[3] = 12'hF00;
        presets[4] = 12'h0F0;
        presets[5] = 12'h0E0;
        presets[6] = 12'h0D0;
        presets[7] = 12'h0C0;
        rst_n    = 1'b0;
        en       = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;

        test_reset();
        test_soft_start();
        test_bounds_low();
        test_small_move();
        test_multi_step_down();
        test_retarget();
        test_freeze();
        test_reset_mid_ramp();
        test_bounds_high();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/setpoint_sequencer.md
Name: setpoint_sequencer

Overview:
- Selects which of the eight 12-bit preset setpoints feeds the regulator loop by driving the 3-bit select of the setpoint multiplexer.
- Never applies a new preset as a step. It slews the active setpoint toward the selected preset in fixed increments at a programmable tick rate, which limits output-voltage overshoot.
- Sits between the debounced user up/down controls and the error/PI stage. After reset it soft-starts from 0 to preset 0.

Parameters:
- W, 12, setpoint width; matches the mux data width.
- STEP, 16, maximum setpoint change per ramp tick (unsigned, 1..2^W-1).
- TICK_DIV, 1000, clock cycles per ramp tick (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  ramp enable; 0 freezes the ramp and tick counter.
- btn_up  input  1  debounced, synchronised level; a rising edge requests the next preset.
- btn_down  input  1  debounced, synchronised level; a rising edge requests the previous preset.
- mux_y  input  W  selected preset, returned combinationally from the setpoint mux.
- sel  output  3  preset select, drives the mux select.
- setpoint  output  W  ramped setpoint to the control loop.
- busy  output  1  high while a ramp is pending or in progress.
- done  output  1  one-cycle pulse when setpoint reaches the target.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n); all flops clear on rst_n=0.
- Reset values:
  - sel=0, setpoint=0, done=0, busy=0.
  - Edge-detect registers=0, tick counter=0, target=0, state=LOAD.
  - busy rises on the first clock after reset release.
- Edge detect: a request is btn & ~btn_q (registered previous level).
  - Simultaneous up and down edges in the same cycle cancel; no action.
- States:
  - IDLE: busy=0.
    - Up edge with sel<7: sel<=sel+1, go to LOAD.
    - Down edge with sel>0: sel<=sel-1, go to LOAD.
    - Up at sel=7, or down at sel=0: ignored; stay in IDLE, no done.
  - LOAD: busy=1.
    - target<=mux_y (mux output for the already-updated sel), tick counter<=0, go to RAMP.
    - Exactly one cycle.
  - RAMP: busy=1.
    - Tick counter counts 0..TICK_DIV-1 while en=1, holds while en=0.
    - At count TICK_DIV-1 with en=1 (a tick), the counter wraps to 0 and:
      - If |target-setpoint| <= STEP: setpoint<=target, done=1 for that cycle, go to IDLE.
      - Else if target>setpoint: setpoint<=setpoint+STEP.
      - Else: setpoint<=setpoint-STEP.
    - The compare uses W+1-bit signed difference. The result can never overflow or underflow W bits, because a step occurs only when at least STEP away.
    - Retarget: a valid up/down edge in RAMP updates sel as in IDLE and goes to LOAD. setpoint keeps its current value, so the ramp continues from there toward the new target with no jump.
    - Invalid edges in RAMP (at a bound, or simultaneous) are ignored.
- target==setpoint on entering RAMP (e.g. two presets hold equal values): done on the first tick, no change to setpoint.
- mux_y changing while in RAMP or IDLE is not tracked. A preset is captured only in LOAD.
- Latency:
  - Edge to sel change: 1 cycle after the button register.
  - Capture: 1 cycle.
  - First setpoint change: TICK_DIV cycles after entering RAMP (with en=1).
- done is never asserted in the same cycle as busy=0 from a prior IDLE; it is asserted on the RAMP→IDLE transition cycle only.
- Reset mid-ramp: immediate return to the reset values; soft-start then repeats from 0 to preset 0.

Test Plan:
1. Soft-start. TICK_DIV=4, STEP=16, preset0=0x100; release reset, en=1.
   - setpoint steps 0→16→…→256, one step every 4 cycles (16 steps).
   - done pulses once, then busy=0, sel=0.
2. Small move. From the idle state of test 1, preset1=0x0F8; pulse btn_up.
   - sel=1, LOAD captures 0x0F8.
   - At the first tick setpoint=0x0F8 (diff 8<=STEP), done pulses.
3. Bounds and conflict:
   - At sel=7, pulse btn_up: no state change, no busy.
   - At sel=0, pulse btn_down: no state change, no busy.
   - btn_up and btn_down rising in the same cycle: no change.
4. Retarget. Ramp 0x000→0xF00 in progress at setpoint=0x200; pulse btn_down.
   - sel decrements, new target 0x080.
   - setpoint continues 0x200→0x1F0→…→0x080 with no discontinuity; exactly one done.
5. Freeze. Mid-ramp, hold en=0 for 20 cycles.
   - setpoint and tick counter hold.
   - After en=1, the next step occurs after the remaining count, not a full TICK_DIV.
6. Reset mid-ramp. Assert rst_n=0 asynchronously between clock edges at setpoint=0x300.
   - Outputs go to reset values immediately.
   - After release, the soft-start toward preset0 repeats.
